// File: rtl/matrix_rd_arbiter_if.sv
// AXI4 memory-mapped port shared between the read arbiter and downstream memory.
// Read channels are complete; write channels exist only so they can be tied off.
interface axi_mm #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/matrix_rd_arbiter.sv
// Round-robin AR arbiter sharing one AXI4 read master among NUM_REQ engines.
// ARID carries the requester index so R beats can be steered back by RID.
module matrix_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  input  logic [NUM_REQ-1:0][63:0]  req_araddr,
  input  logic [NUM_REQ-1:0][7:0]   req_arlen,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [511:0]              req_rdata,
  output logic                      req_rlast,
  axi_mm.master                     m,
  output logic [NUM_REQ-1:0][6:0]   outstanding,
  output logic [31:0]               ar_issued_cnt,
  output logic [31:0]               r_last_cnt,
  output logic                      err
);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [2:0]         winner;
  logic [3:0]         sum;
  logic               found;
  logic               grant;
  logic [NUM_REQ-1:0] eligible;
  logic [63:0]        sel_addr;
  logic [7:0]         sel_len;
  logic               arvalid_q;
  logic [63:0]        araddr_q;
  logic [7:0]         arlen_q;
  logic [3:0]         arid_q;
  logic               rid_ok;
  logic               rready_sel;
  logic               last_fire;
  logic [NUM_REQ-1:0] dec_hit;
  logic               dec_zero;
  logic               unused_slave;

  // Search from rr_ptr upward with wrap; the lowest offset that is eligible wins.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    winner   = '0;
    sum      = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_arvalid[i] && (outstanding[i] < 7'(MAX_OUTSTANDING));
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      if (sum >= 4'(NUM_REQ))
        sum = sum - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++)
        if (sum == 4'(j) && eligible[j]) begin
          found  = 1'b1;
          winner = 3'(j);
        end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (winner == 3'(i)) begin
        sel_addr = req_araddr[i];
        sel_len  = req_arlen[i];
      end
  end

  assign grant = found && (state == ARB) && !rst;

  always_comb begin
    req_arready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_arready[i] = grant && (winner == 3'(i));
  end

  // R steering; an out-of-range RID is always accepted so the bus never stalls on it.
  always_comb begin
    rid_ok     = (m.rid < 4'(NUM_REQ));
    rready_sel = !rid_ok;
    req_rvalid = '0;
    dec_hit    = '0;
    dec_zero   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (m.rid == 4'(i)) begin
        req_rvalid[i] = m.rvalid;
        rready_sel    = req_rready[i];
      end
    last_fire = m.rvalid && rready_sel && m.rlast;
    for (int i = 0; i < NUM_REQ; i++)
      if (last_fire && m.rid == 4'(i)) begin
        if (outstanding[i] == 7'd0)
          dec_zero = 1'b1;
        else
          dec_hit[i] = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      rr_ptr        <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arid_q        <= '0;
      ar_issued_cnt <= '0;
      r_last_cnt    <= '0;
      err           <= 1'b0;
      outstanding   <= '0;
    end else begin
      case (state)
        ARB: if (grant) begin
          araddr_q  <= sel_addr;
          arlen_q   <= sel_len;
          arid_q    <= {1'b0, winner};
          arvalid_q <= 1'b1;
          rr_ptr    <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
          state     <= ISSUE;
        end
        ISSUE: if (m.arready) begin
          arvalid_q     <= 1'b0;
          ar_issued_cnt <= ar_issued_cnt + 32'd1;
          state         <= ARB;
        end
        default: state <= ARB;
      endcase
      if (last_fire)
        r_last_cnt <= r_last_cnt + 32'd1;
      if (dec_zero || (m.rvalid && !rid_ok))
        err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        outstanding[i] <= outstanding[i] + 7'(req_arready[i]) - 7'(dec_hit[i]);
    end
  end

  assign m.arvalid  = arvalid_q;
  assign m.araddr   = araddr_q;
  assign m.arlen    = arlen_q;
  assign m.arid     = arid_q;
  assign m.arsize   = 3'b110;
  assign m.arburst  = 2'b01;
  assign m.arlock   = 1'b0;
  assign m.arcache  = 4'd0;
  assign m.arprot   = 3'b010;
  assign m.arqos    = 4'd0;
  assign m.arregion = 4'd0;
  assign m.rready   = rready_sel;

  assign req_rdata  = m.rdata;
  assign req_rlast  = m.rlast;

  // This block never writes, so every write channel stays idle.
  assign m.awid     = '0;
  assign m.awaddr   = '0;
  assign m.awlen    = '0;
  assign m.awsize   = '0;
  assign m.awburst  = '0;
  assign m.awvalid  = 1'b0;
  assign m.wdata    = '0;
  assign m.wstrb    = '0;
  assign m.wlast    = 1'b0;
  assign m.wvalid   = 1'b0;
  assign m.bready   = 1'b0;

  assign unused_slave = ^{m.rresp, m.awready, m.wready, m.bid, m.bresp, m.bvalid};

endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// Self-checking bench for matrix_rd_arbiter: R-routing vector table, directed
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_matrix_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]       req_arvalid, req_arready, req_rvalid, req_rready;
  logic [3:0][63:0] req_araddr;
  logic [3:0][7:0]  req_arlen;
  logic [511:0]     req_rdata;
  logic             req_rlast;
  logic [3:0][6:0]  outstanding;
  logic [31:0]      ar_issued_cnt, r_last_cnt;
  logic             err;

  axi_mm m_if ();

  matrix_rd_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_arvalid   (req_arvalid),
    .req_arready   (req_arready),
    .req_araddr    (req_araddr),
    .req_arlen     (req_arlen),
    .req_rvalid    (req_rvalid),
    .req_rready    (req_rready),
    .req_rdata     (req_rdata),
    .req_rlast     (req_rlast),
    .m             (m_if),
    .outstanding   (outstanding),
    .ar_issued_cnt (ar_issued_cnt),
    .r_last_cnt    (r_last_cnt),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rvalid;
    logic [3:0] rid;
    logic [3:0] rready;
    logic [3:0] exp_rvalid;
    logic       exp_mrready;
    logic       exp_err;
  } rvec_t;

  typedef struct {
    int id;
    int len;
  } burst_t;

  rvec_t  rtab [8];
  burst_t pend [$];
  logic [3:0] rq [$];

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [3:0] id, input logic rl, input logic [3:0] rr);
    m_if.rvalid = rv;
    m_if.rid    = id;
    m_if.rlast  = rl;
    req_rready  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req_arvalid  = '0;
    req_araddr   = '0;
    req_arlen    = '0;
    m_if.arready = 1'b0;
    m_if.rdata   = '0;
    m_if.rresp   = '0;
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bid     = '0;
    m_if.bresp   = '0;
    m_if.bvalid  = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gcnt [4];
    int exp_next, w, g1, g2, got, beat, rid_i;
    int m_out [4];
    int m_ptr, m_id, m_issued, m_rlast;
    bit m_issuing;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [3:0]  exp_ar, exp_rv;
    logic [27:0] exp_out;
    logic        exp_rr;

    // rvalid, rid, req_rready, expected req_rvalid, expected m.rready, expected err
    rtab[0] = '{1'b0, 4'd0,  4'b1111, 4'b0000, 1'b1, 1'b0};
    rtab[1] = '{1'b1, 4'd0,  4'b0001, 4'b0001, 1'b1, 1'b0};
    rtab[2] = '{1'b1, 4'd1,  4'b1101, 4'b0010, 1'b0, 1'b0};
    rtab[3] = '{1'b1, 4'd2,  4'b0100, 4'b0100, 1'b1, 1'b0};
    rtab[4] = '{1'b1, 4'd3,  4'b0111, 4'b1000, 1'b0, 1'b0};
    rtab[5] = '{1'b0, 4'd2,  4'b0000, 4'b0000, 1'b0, 1'b0};
    rtab[6] = '{1'b1, 4'd5,  4'b0000, 4'b0000, 1'b1, 1'b0};
    rtab[7] = '{1'b1, 4'd15, 4'b1111, 4'b0000, 1'b1, 1'b1};

    // Reset state
    do_reset();
    settle();
    checkOutput("rst_arvalid", 64'(m_if.arvalid), 64'd0);
    checkOutput("rst_arready", 64'(req_arready), 64'd0);
    checkOutput("rst_rvalid", 64'(req_rvalid), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_ar_cnt", 64'(ar_issued_cnt), 64'd0);
    checkOutput("rst_rlast_cnt", 64'(r_last_cnt), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);

    // Single requester: one 8-beat burst
    req_arvalid   = 4'b0001;
    req_araddr[0] = 64'h1000;
    req_arlen[0]  = 8'd7;
    m_if.arready  = 1'b1;
    settle();
    checkOutput("single_grant", 64'(req_arready), 64'b0001);
    tick();
    req_arvalid = 4'b0000;
    settle();
    checkOutput("single_arvalid", 64'(m_if.arvalid), 64'd1);
    checkOutput("single_arid", 64'(m_if.arid), 64'd0);
    checkOutput("single_araddr", m_if.araddr, 64'h1000);
    checkOutput("single_arlen", 64'(m_if.arlen), 64'd7);
    checkOutput("single_arconst", 64'({m_if.arsize, m_if.arburst, m_if.arprot}), 64'({3'b110, 2'b01, 3'b010}));
    checkOutput("single_out_1", 64'(outstanding[0]), 64'd1);
    tick();
    settle();
    checkOutput("single_ar_drop", 64'(m_if.arvalid), 64'd0);
    checkOutput("single_ar_cnt", 64'(ar_issued_cnt), 64'd1);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b1, 4'd0, (b == 7), 4'b0001);
      m_if.rdata = 512'(b + 1);
      settle();
      checkOutput("single_rvalid", 64'(req_rvalid), 64'b0001);
      checkOutput("single_rdata", 64'(req_rdata), 64'(b + 1));
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("single_out_0", 64'(outstanding[0]), 64'd0);
    checkOutput("single_rlast_cnt", 64'(r_last_cnt), 64'd1);

    // Fairness: all requesters asking continuously, single-beat bursts returned promptly
    do_reset();
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    exp_next     = 0;
    req_arvalid  = 4'b1111;
    m_if.arready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (rq.size() > 0) applyStimulus(1'b1, rq[0], 1'b1, 4'b1111);
      else               applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
      settle();
      if (req_arready != 4'b0000) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (req_arready[i]) w = i;
        checkOutput("fair_order", 64'(w), 64'(exp_next));
        gcnt[w]++;
        exp_next = (exp_next + 1) % 4;
      end
      if (m_if.rvalid && m_if.rready) void'(rq.pop_front());
      if (m_if.arvalid && m_if.arready) rq.push_back(m_if.arid);
      tick();
    end
    req_arvalid = 4'b0000;
    for (int c = 0; c < 10 && rq.size() > 0; c++) begin
      applyStimulus(1'b1, rq[0], 1'b1, 4'b1111);
      settle();
      if (m_if.rvalid && m_if.rready) void'(rq.pop_front());
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("fair_drain", 64'(rq.size()), 64'd0);
    checkOutput("fair_ar_cnt", 64'(ar_issued_cnt), 64'd200);
    checkOutput("fair_rlast_cnt", 64'(r_last_cnt), 64'd200);
    for (int i = 0; i < 4; i++) checkOutput("fair_grants", 64'(gcnt[i]), 64'd50);
    checkOutput("fair_out", 64'(outstanding), 64'd0);

    // Outstanding limit: req 1 saturates while req 2 is still served
    do_reset();
    req_arvalid  = 4'b0010;
    m_if.arready = 1'b1;
    g1 = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (req_arready[1]) g1++;
      tick();
    end
    checkOutput("limit_grants", 64'(g1), 64'd16);
    checkOutput("limit_out16", 64'(outstanding[1]), 64'd16);
    req_arvalid = 4'b0110;
    g1 = 0;
    g2 = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (req_arready[1]) g1++;
      if (req_arready[2]) g2++;
      tick();
    end
    checkOutput("limit_block", 64'(g1), 64'd0);
    checkOutput("limit_other", 64'(g2), 64'd5);
    req_arvalid = 4'b0010;
    applyStimulus(1'b1, 4'd1, 1'b1, 4'b1111);
    settle();
    checkOutput("limit_rready", 64'(m_if.rready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      settle();
      if (req_arready[1]) got = 1;
      tick();
    end
    checkOutput("limit_regrant", 64'(got), 64'd1);

    // R backpressure on rid 2
    do_reset();
    req_arvalid  = 4'b0100;
    m_if.arready = 1'b1;
    settle();
    tick();
    req_arvalid = 4'b0000;
    settle();
    tick();
    applyStimulus(1'b1, 4'd2, 1'b1, 4'b1011);
    settle();
    checkOutput("bp_rready_low", 64'(m_if.rready), 64'd0);
    checkOutput("bp_rvalid", 64'(req_rvalid), 64'b0100);
    tick();
    settle();
    checkOutput("bp_held", 64'(outstanding[2]), 64'd1);
    applyStimulus(1'b1, 4'd2, 1'b1, 4'b1111);
    settle();
    checkOutput("bp_rready_high", 64'(m_if.rready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("bp_out_0", 64'(outstanding[2]), 64'd0);
    checkOutput("bp_rlast_cnt", 64'(r_last_cnt), 64'd1);

    // R routing vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(rtab[i].rvalid, rtab[i].rid, 1'b0, rtab[i].rready);
      settle();
      checkOutput("rtab_rvalid", 64'(req_rvalid), 64'(rtab[i].exp_rvalid));
      checkOutput("rtab_rready", 64'(m_if.rready), 64'(rtab[i].exp_mrready));
      checkOutput("rtab_err", 64'(err), 64'(rtab[i].exp_err));
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("rtab_err_final", 64'(err), 64'd1);
    checkOutput("rtab_out", 64'(outstanding), 64'd0);

    // Error paths: bad RID, then an rlast with nothing outstanding
    do_reset();
    settle();
    checkOutput("err_cleared", 64'(err), 64'd0);
    applyStimulus(1'b1, 4'd5, 1'b0, 4'b0000);
    settle();
    checkOutput("err_bad_rready", 64'(m_if.rready), 64'd1);
    checkOutput("err_bad_rvalid", 64'(req_rvalid), 64'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("err_set", 64'(err), 64'd1);
    applyStimulus(1'b1, 4'd3, 1'b1, 4'b1111);
    settle();
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'b1111);
    settle();
    checkOutput("err_zero_out", 64'(outstanding[3]), 64'd0);
    checkOutput("err_sticky", 64'(err), 64'd1);

    // Reset while ISSUE is holding arvalid
    do_reset();
    req_arvalid   = 4'b0001;
    req_araddr[0] = 64'h2000;
    settle();
    tick();
    req_arvalid = 4'b0000;
    settle();
    checkOutput("rstiss_arvalid", 64'(m_if.arvalid), 64'd1);
    tick();
    settle();
    checkOutput("rstiss_hold", 64'(m_if.arvalid), 64'd1);
    checkOutput("rstiss_addr", m_if.araddr, 64'h2000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checkOutput("rstiss_drop", 64'(m_if.arvalid), 64'd0);
    checkOutput("rstiss_out", 64'(outstanding), 64'd0);
    checkOutput("rstiss_cnt", 64'(ar_issued_cnt), 64'd0);
    req_arvalid   = 4'b1000;
    req_araddr[3] = 64'h3000;
    m_if.arready  = 1'b1;
    settle();
    checkOutput("rstiss_regrant", 64'(req_arready), 64'b1000);
    tick();
    req_arvalid = 4'b0000;
    settle();
    checkOutput("rstiss_arid", 64'(m_if.arid), 64'd3);
    tick();
    settle();
    checkOutput("rstiss_cnt1", 64'(ar_issued_cnt), 64'd1);
    checkOutput("rstiss_out3", 64'(outstanding[3]), 64'd1);

    // Randomized traffic against the behavioural model
    do_reset();
    for (int i = 0; i < 4; i++) m_out[i] = 0;
    m_ptr     = 0;
    m_issuing = 1'b0;
    m_addr    = '0;
    m_len     = '0;
    m_id      = 0;
    m_issued  = 0;
    m_rlast   = 0;
    beat      = 0;
    pend.delete();
    for (int c = 0; c < 1500; c++) begin
      req_arvalid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        req_araddr[i] = {$urandom, $urandom};
        req_arlen[i]  = 8'($urandom_range(0, 3));
      end
      m_if.arready = ($urandom_range(0, 3) != 0);
      m_if.rdata   = {16{$urandom}};
      if (pend.size() > 0 && $urandom_range(0, 1) == 1)
        applyStimulus(1'b1, 4'(pend[0].id), (beat == pend[0].len), 4'($urandom));
      else
        applyStimulus(1'b0, 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
      settle();

      w = -1;
      if (!m_issuing)
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (w < 0 && req_arvalid[j] && m_out[j] < 16) w = j;
        end
      exp_ar = (w >= 0) ? 4'(1 << w) : 4'b0000;
      rid_i  = int'(m_if.rid);
      exp_rv = m_if.rvalid ? 4'(1 << rid_i) : 4'b0000;
      exp_rr = req_rready[rid_i];
      exp_out = '0;
      for (int i = 0; i < 4; i++) exp_out[i*7 +: 7] = 7'(m_out[i]);

      checkOutput("rnd_arready", 64'(req_arready), 64'(exp_ar));
      checkOutput("rnd_arvalid", 64'(m_if.arvalid), 64'(m_issuing));
      if (m_issuing) begin
        checkOutput("rnd_araddr", m_if.araddr, m_addr);
        checkOutput("rnd_arid_len", 64'({m_if.arid, m_if.arlen}), 64'({4'(m_id), m_len}));
      end
      checkOutput("rnd_rvalid", 64'(req_rvalid), 64'(exp_rv));
      checkOutput("rnd_rready", 64'(m_if.rready), 64'(exp_rr));
      checkOutput("rnd_outstanding", 64'(outstanding), 64'(exp_out));
      checkOutput("rnd_counters", {ar_issued_cnt, r_last_cnt}, {32'(m_issued), 32'(m_rlast)});

      if (w >= 0) begin
        m_out[w]++;
        m_ptr     = (w + 1) % 4;
        m_addr    = req_araddr[w];
        m_len     = req_arlen[w];
        m_id      = w;
        m_issuing = 1'b1;
      end else if (m_issuing && m_if.arready) begin
        pend.push_back('{m_id, int'(m_len)});
        m_issued++;
        m_issuing = 1'b0;
      end
      if (m_if.rvalid && exp_rr) begin
        if (m_if.rlast) begin
          m_out[pend[0].id]--;
          void'(pend.pop_front());
          m_rlast++;
          beat = 0;
        end else begin
          beat++;
        end
      end
      tick();
    end
    settle();
    checkOutput("rnd_err", 64'(err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_rd_arbiter.md
# matrix_rd_arbiter

Round-robin scheduler that shares one AXI4 read master between NUM_REQ matrix read engines. Each engine presents AR requests on a light valid/ready port. The arbiter tags each granted request with ARID equal to the requester index and issues it on the shared `axi_mm` master. Returning R beats are steered back by RID. It also tracks per-requester outstanding bursts and exposes counters for the control/status register file.

## Interface
Parameters:
- NUM_REQ, 4 — number of requesters; must be 2..8; ARID width is 4.
- MAX_OUTSTANDING, 16 — maximum in-flight bursts per requester; power of two, at most 64.

Ports:
- clk  in  1  — the single clock; all logic is on its rising edge.
- rst  in  1  — synchronous reset, active-high.
- req_arvalid  in  NUM_REQ  — per-requester AR request.
- req_arready  out  NUM_REQ  — per-requester grant; the handshake completes on the edge when valid and ready are both high.
- req_araddr  in  NUM_REQ×64  — burst byte address.
- req_arlen  in  NUM_REQ×8  — AXI arlen, i.e. beats minus 1.
- req_rvalid  out  NUM_REQ  — R beat valid for the requester selected by RID.
- req_rready  in  NUM_REQ  — per-requester R backpressure.
- req_rdata  out  512  — broadcast copy of m.rdata.
- req_rlast  out  1  — broadcast copy of m.rlast.
- m  axi_mm.master  —  — shared downstream read port; write channels are tied inactive.
- outstanding  out  NUM_REQ×7  — per-requester in-flight burst count.
- ar_issued_cnt  out  32  — total AR handshakes completed on m; wraps.
- r_last_cnt  out  32  — total rlast beats accepted on m; wraps.
- err  out  1  — sticky error flag.

## Operation
- FSM has two states: ARB and ISSUE. Reset enters ARB.
- In ARB:
  - A requester is eligible when req_arvalid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
  - The winner is the first eligible index found searching from rr_ptr upward, with modulo NUM_REQ wrap.
  - req_arready[winner] is driven combinationally, high only in ARB; all other bits are 0.
- On the winner's handshake:
  - Latch req_araddr/req_arlen into m.araddr/m.arlen.
  - Set m.arid to the winner index.
  - Increment outstanding[winner].
  - Set rr_ptr to (winner+1) mod NUM_REQ.
  - Go to ISSUE.
- In ISSUE:
  - Hold m.arvalid=1 with stable address, length and ID.
  - On m.arready, drop arvalid next cycle, increment ar_issued_cnt, and return to ARB.
- Constant AR fields: arsize=3'b110 (64 B/beat), arburst=INCR, arlock=0, arcache=0, arprot=3'b010, arqos=0, arregion=0.
- R path is combinational, selected by i = m.rid:
  - req_rvalid[i] = m.rvalid.
  - m.rready = req_rready[i].
  - All other req_rvalid bits are 0.
- On m.rvalid & m.rready & m.rlast: decrement outstanding[rid] and increment r_last_cnt.
- Increment and decrement of the same counter in one cycle leave it unchanged.
- Boundary conditions:
  - A requester at MAX_OUTSTANDING is skipped; other requesters proceed.
  - rid ≥ NUM_REQ: m.rready=1, the beat is dropped, err is set.
  - A decrement when the counter is 0 is ignored and sets err.
  - rst mid-burst clears all state. R beats still in flight afterwards trigger the err path, so the controller must drain m before asserting rst.
  - err clears only on rst.

## Timing
- Reset values:
  - m.arvalid=0, req_arready=0, req_rvalid=0.
  - outstanding=0, ar_issued_cnt=0, r_last_cnt=0, err=0.
  - rr_ptr=0, state=ARB.
- Latency:
  - Request handshake at edge N → m.arvalid high from cycle N+1.
  - Peak AR rate is one burst per 2 cycles when m.arready=1.
- m.arvalid never deasserts before m.arready. AR fields are constant while arvalid is high.
- R path has zero latency: req_rvalid and m.rready follow m.rvalid/m.rid and req_rready in the same cycle.
- outstanding, ar_issued_cnt and r_last_cnt are registered; they update one cycle after the qualifying event.

## Test plan
- **Single requester:** req 0 issues addr 0x1000, arlen 7; m.arready=1 → m.arid=0 and m.araddr=0x1000 one cycle after grant; 8 R beats routed to req_rvalid[0]; outstanding[0] goes 0→1→0; ar_issued_cnt=1; r_last_cnt=1.
- **Fairness:** all 4 requesters hold arvalid continuously → grant order 0,1,2,3,0,1…; over 400 cycles ar_issued_cnt=200 with 50 grants each.
- **Outstanding limit:** req 1 issues 16 bursts with R withheld → 17th not granted while req 2 is still served; one rlast for rid 1 → req 1 granted again.
- **R backpressure:** rid=2 beat with req_rready[2]=0 → m.rready=0, beat held; raising req_rready[2] → beat accepted.
- **Errors:** rid=5 beat → m.rready=1, no req_rvalid asserted, err=1; then rlast for rid 3 with outstanding[3]=0 → counter stays 0, err stays 1.
- **Reset:** rst during ISSUE → next cycle m.arvalid=0 and all counters 0; a following request is granted normally.
